slow_clock_ctrl: RTL and testbench
==================================

SLOW_CLOCK_CTRL -- requirements
Module: slow_clock_ctrl

Interface
REQ-001 Parameter FactorWidth, default 8, width of the half-period factor.
REQ-002 Parameter DefaultFactor, default 8, factor loaded by reset; nonzero.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command can be accepted this cycle.
REQ-007 cmd_op  in  2  00 NOP, 01 LOAD, 10 START, 11 STOP.
REQ-008 cmd_factor  in  FactorWidth  new half-period for LOAD.
REQ-009 outclock  out  1  generated slow clock, registered.
REQ-010 tick  out  1  one-cycle pulse coincident with each outclock 0->1 transition.
REQ-011 running  out  1  high in RUN, PENDING, STOPPING.
REQ-012 factor  out  FactorWidth  currently active factor.
REQ-013 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-014 A command is accepted at the rising edge where cmd_valid and cmd_ready are both 1; its effects are visible in the next cycle.
REQ-015 States: IDLE, RUN, PENDING (RUN with a load waiting), STOPPING.
REQ-016 cmd_ready = 1 in IDLE and RUN; 0 in PENDING and STOPPING.
REQ-017 Internal counter cnt, FactorWidth bits, increments by 1 each cycle while running; no other arithmetic.
REQ-018 IDLE + START: state <- RUN, outclock <- 1, tick <- 1, cnt <- 0.
REQ-019 In RUN/PENDING/STOPPING, at the edge where cnt == factor-1: cnt <- 0 and outclock toggles; otherwise cnt increments and outclock holds.
REQ-020 Result: outclock high for exactly factor cycles, low for exactly factor cycles; period 2*factor; factor = 1 gives period 2.
REQ-021 tick is 1 only in the cycle after each 0->1 toggle edge (including START); 0 otherwise.
REQ-022 IDLE + LOAD with cmd_factor != 0: factor <- cmd_factor at the accept edge.
REQ-023 RUN + LOAD with cmd_factor != 0: value held in a pending register, state <- PENDING.
REQ-024 PENDING: at the next 0->1 toggle edge, factor <- pending value, state <- RUN; the interrupted period completes with the old factor.
REQ-025 LOAD with cmd_factor == 0 in any accepting state: command consumed, factor and state unchanged, err = 1 for one cycle.
REQ-026 RUN + STOP: state <- STOPPING; the current period completes with the current factor.
REQ-027 STOPPING: at the edge where outclock would go 0->1, outclock stays 0, tick stays 0, cnt <- 0, state <- IDLE.
REQ-028 START in RUN, STOP in IDLE, and NOP anywhere: accepted, no effect, err stays 0.
REQ-029 outclock never produces a high or low phase shorter than the active factor, including across LOAD and STOP.

Reset
REQ-030 reset = 1 at an edge overrides any command and any counter event that cycle.
REQ-031 Reset values: state IDLE, outclock 0, tick 0, running 0, err 0, cnt 0, factor DefaultFactor, pending cleared, cmd_ready 1.
REQ-032 Reset asserted mid-period, in any state, takes effect at that edge; the partial period is abandoned.

Verification
REQ-033 Reset, then START: outclock 1 for cycles 1-8 and 0 for cycles 9-16; tick in cycles 1, 17, 33; running = 1.
REQ-034 IDLE: LOAD 3, then START: factor = 3, period 6, tick every 6 cycles.
REQ-035 RUN at factor 8: LOAD 2 in high-phase cycle 3: cmd_ready 0 until the next rise; that period lasts 16; following periods last 4; cmd_ready then returns to 1.
REQ-036 RUN at factor 8: STOP in high-phase cycle 2: 6 more high cycles and 8 low cycles, then outclock stays 0 with no tick; running and cmd_ready settle to 0 and 1.
REQ-037 LOAD 0 in IDLE and again in RUN: err pulses one cycle each time; factor stays 8; state unchanged; cmd_ready stays 1.
REQ-038 reset asserted in PENDING, outclock high: next cycle all outputs equal REQ-031 values, factor = 8, pending load discarded.

Source files
------------

// File: rtl/slow_clock_ctrl.sv
// Programmable slow-clock generator: outclock high for `factor` cycles and low for `factor`
// cycles, with deferred factor reloads and glitch-free stop at the end of a full period.
module slow_clock_ctrl #(
  parameter int unsigned FactorWidth   = 8,
  parameter int unsigned DefaultFactor = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [FactorWidth-1:0] cmd_factor,
  output logic                   outclock,
  output logic                   tick,
  output logic                   running,
  output logic [FactorWidth-1:0] factor,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, RUN, PENDING, STOPPING} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_START, OP_STOP} op_t;

  state_t                 state, state_n;
  logic [FactorWidth-1:0] cnt, cnt_n;
  logic [FactorWidth-1:0] factor_n;
  logic [FactorWidth-1:0] pend, pend_n;
  logic                   outclock_n, tick_n, err_n;
  logic                   accept, wrap;

  assign cmd_ready = (state == IDLE) || (state == RUN);
  assign running   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      factor   <= FactorWidth'(DefaultFactor);
      pend     <= '0;
      outclock <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      factor   <= factor_n;
      pend     <= pend_n;
      outclock <= outclock_n;
      tick     <= tick_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    factor_n   = factor;
    pend_n     = pend;
    outclock_n = outclock;
    tick_n     = 1'b0;
    err_n      = 1'b0;
    accept     = cmd_valid && cmd_ready;
    wrap       = (cnt == (factor - FactorWidth'(1)));

    // Phase counter; factor changes and stops only take effect on a rising edge,
    // so no phase is ever shortened.
    if (state != IDLE) begin
      if (wrap) begin
        cnt_n = '0;
        if (!outclock) begin
          if (state == STOPPING) begin
            state_n = IDLE;
          end else begin
            outclock_n = 1'b1;
            tick_n     = 1'b1;
            if (state == PENDING) begin
              factor_n = pend;
              state_n  = RUN;
            end
          end
        end else begin
          outclock_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + FactorWidth'(1);
      end
    end

    if (accept) begin
      case (op_t'(cmd_op))
        OP_LOAD: begin
          if (cmd_factor == '0) begin
            err_n = 1'b1;
          end else if (state == IDLE) begin
            factor_n = cmd_factor;
          end else begin
            pend_n  = cmd_factor;
            state_n = PENDING;
          end
        end
        OP_START: begin
          if (state == IDLE) begin
            state_n    = RUN;
            outclock_n = 1'b1;
            tick_n     = 1'b1;
            cnt_n      = '0;
          end
        end
        OP_STOP: begin
          if (state == RUN) state_n = STOPPING;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clock_ctrl.sv
// Table-driven bench for slow_clock_ctrl: per-cycle vectors, expectations queued as each
// vector is driven and checked one cycle later, #1 after the rising edge.
module tb_slow_clock_ctrl;

  localparam logic [1:0] NOP = 2'd0, LOAD = 2'd1, START = 2'd2, STOP = 2'd3;

  typedef struct {
    string      nm;
    bit         rst;
    bit         valid;
    bit [1:0]   op;
    bit [7:0]   cf;
    bit         oc;
    bit         tk;
    bit         run;
    bit         rdy;
    bit         er;
    bit [7:0]   fac;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_factor = 8'd0;
  logic       outclock, tick, running, err;
  logic [7:0] factor;

  vec_t vecs[$];
  vec_t sb[$];
  int   applied = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  slow_clock_ctrl #(.FactorWidth(8), .DefaultFactor(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_factor (cmd_factor),
    .outclock   (outclock),
    .tick       (tick),
    .running    (running),
    .factor     (factor),
    .err        (err)
  );

  always #5 clock = ~clock;

  function automatic void add(string nm, bit rst, bit valid, bit [1:0] op, bit [7:0] cf,
                              bit oc, bit tk, bit run, bit rdy, bit er, bit [7:0] fac);
    vec_t v;
    v.nm = nm; v.rst = rst; v.valid = valid; v.op = op; v.cf = cf;
    v.oc = oc; v.tk = tk; v.run = run; v.rdy = rdy; v.er = er; v.fac = fac;
    vecs.push_back(v);
  endfunction

  // Idle NOP cycles c0..c1 of a free-running clock whose rising edge lands in cycle `base`.
  function automatic void add_run(string nm, int c0, int c1, int base, int f, bit rdy, bit [7:0] fac);
    for (int c = c0; c <= c1; c++) begin
      int p = (c - base) % (2 * f);
      add(nm, 1'b0, 1'b0, NOP, 8'd0, p < f, p == 0, 1'b1, rdy, 1'b0, fac);
    end
  endfunction

  function automatic void add_rst(string nm);
    add(nm, 1'b1, 1'b0, NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);
  endfunction

  function automatic void add_start(string nm, bit [7:0] fac);
    add(nm, 1'b0, 1'b1, START, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, fac);
  endfunction

  initial begin
    int budget;
    wait (vecs.size() > 0);
    budget = 10 * (vecs.size() + 20);
    fork
      wait (done);
      repeat (budget) @(posedge clock);
    join_any
    disable fork;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: vector stream did not complete within %0d cycles (%0d applied)",
               budget, applied);
      $finish;
    end
  end

  initial begin
    // Reset values
    add_rst("reset0");
    add_rst("reset1");

    // Default factor 8: high cycles 1-8, low 9-16, ticks at 1, 17, 33
    add_start("start8", 8'd8);
    add_run("run8", 2, 33, 1, 8, 1'b1, 8'd8);
    add_rst("rst_a");

    // Rejected LOAD 0 in IDLE, then benign NOP / STOP in IDLE
    add("ld0_idle", 1'b0, 1'b1, LOAD, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd8);
    add("nop_idle", 1'b0, 1'b1, NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);
    add("stop_idle", 1'b0, 1'b1, STOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);

    // LOAD 3 in IDLE, period 6, then rejected LOAD 0 while running
    add("ld3_idle", 1'b0, 1'b1, LOAD, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    add_start("start3", 8'd3);
    add_run("run3", 2, 13, 1, 3, 1'b1, 8'd3);
    add("ld0_run", 1'b0, 1'b1, LOAD, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
    add_run("run3b", 15, 19, 1, 3, 1'b1, 8'd3);
    add_rst("rst_b");
    add_rst("rst_fac8");

    // LOAD 2 in high cycle 3: 16-cycle period finishes, then period 4
    add_start("start_ld", 8'd8);
    add_run("pre_ld", 2, 3, 1, 8, 1'b1, 8'd8);
    add("ld2_run", 1'b0, 1'b1, LOAD, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
    add_run("pend", 5, 5, 1, 8, 1'b0, 8'd8);
    add("ld_blocked", 1'b0, 1'b1, LOAD, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
    add_run("pend", 7, 16, 1, 8, 1'b0, 8'd8);
    add_run("run2", 17, 28, 17, 2, 1'b1, 8'd2);
    add("start_in_run", 1'b0, 1'b1, START, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
    add_run("run2b", 30, 33, 17, 2, 1'b1, 8'd2);
    add_rst("rst_c");

    // STOP in high cycle 2: period completes, then quiet IDLE
    add_start("start_stop", 8'd8);
    add_run("pre_stop", 2, 2, 1, 8, 1'b1, 8'd8);
    add("stop_run", 1'b0, 1'b1, STOP, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
    add_run("stopping", 4, 16, 1, 8, 1'b0, 8'd8);
    for (int c = 17; c <= 21; c++)
      add("stopped", 1'b0, 1'b0, NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);

    // Factor 1 (period 2) and STOP landing exactly on a rising edge
    add("ld1", 1'b0, 1'b1, LOAD, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    add_start("start1", 8'd1);
    add_run("run1", 2, 6, 1, 1, 1'b1, 8'd1);
    add("stop1", 1'b0, 1'b1, STOP, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    add("stop1_lo", 1'b0, 1'b0, NOP, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    add("stop1_idle", 1'b0, 1'b0, NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    add("stop1_idle", 1'b0, 1'b0, NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    add_rst("rst_d");

    // Reset in PENDING with outclock high, colliding with a START; load discarded
    add_start("start_p", 8'd8);
    add("ld2_p", 1'b0, 1'b1, LOAD, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8);
    add_run("pend_p", 3, 3, 1, 8, 1'b0, 8'd8);
    add("rst_pend", 1'b1, 1'b1, START, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8);
    add_start("restart", 8'd8);
    add_run("run8_post", 2, 18, 1, 8, 1'b1, 8'd8);

    foreach (vecs[i]) begin
      vec_t e;
      @(negedge clock);
      reset      = vecs[i].rst;
      cmd_valid  = vecs[i].valid;
      cmd_op     = vecs[i].op;
      cmd_factor = vecs[i].cf;
      sb.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      applied++;
      if (outclock !== e.oc || tick !== e.tk || running !== e.run || cmd_ready !== e.rdy ||
          err !== e.er || factor !== e.fac) begin
        miscompares++;
        $display("FAIL %s vec %0d: got oc=%b tick=%b run=%b rdy=%b err=%b fac=%0d, want oc=%b tick=%b run=%b rdy=%b err=%b fac=%0d",
                 e.nm, i, outclock, tick, running, cmd_ready, err, factor,
                 e.oc, e.tk, e.run, e.rdy, e.er, e.fac);
      end
      if (e.rst && (outclock !== 1'b0 || tick !== 1'b0 || running !== 1'b0 || err !== 1'b0 ||
                    cmd_ready !== 1'b1 || factor !== 8'd8)) begin
        miscompares++;
        $display("FAIL reset-state %s vec %0d: got oc=%b tick=%b run=%b rdy=%b err=%b fac=%0d",
                 e.nm, i, outclock, tick, running, cmd_ready, err, factor);
      end
    end

    done = 1'b1;
    if (applied != vecs.size() || sb.size() != 0) begin
      miscompares++;
      $display("FAIL completeness: %0d of %0d vectors applied, %0d left in scoreboard",
               applied, vecs.size(), sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
